// File: rtl/crypt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crypt_pkg
//  Description : Shared definitions for the byte-substitution cipher
//                datapaths (encryptor and block_decrypt_serial).
//                - BLOCK_BYTES / BLOCK_W : block geometry
//                - fsm_state_e            : block FSM encodings
//                - round_key()            : per-round key schedule
//  Revision    : 1.0 - initial release
// ============================================================================
package crypt_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = BLOCK_BYTES * 8;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ROUND  = 2'd1,
        UNLOAD = 2'd2
    } fsm_state_e;

    // Round r key: the cipher key with the round number XORed into every byte.
    function automatic logic [BLOCK_W-1:0] round_key(
        input logic [BLOCK_W-1:0] key,
        input logic [7:0]         r
    );
        return key ^ {BLOCK_BYTES{r}};
    endfunction

endpackage : crypt_pkg
`default_nettype wire

// File: rtl/inv_s_box_gf.sv
`default_nettype none
// ============================================================================
//  Module      : inv_s_box_gf
//  Description : 8-bit combinational inverse substitution box.
//                Ports:
//                  sel  in  8  substituted byte
//                  data out 8  recovered byte (sel ^ 8'hFF)
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_s_box_gf (
    input  logic [7:0] sel,
    output logic [7:0] data
);

    assign data = sel ^ 8'hFF;

endmodule : inv_s_box_gf
`default_nettype wire

// File: rtl/block_decrypt_serial.sv
`default_nettype none
// ============================================================================
//  Module      : block_decrypt_serial
//  Description : Byte-serial iterative block decryptor. Loads a 16-byte
//                ciphertext block, runs ROUNDS inverse rounds (one per cycle,
//                round ROUNDS-1 down to 0), then streams 16 plaintext bytes.
//                Ports:
//                  clk        in   1    rising-edge clock
//                  rst        in   1    synchronous active-high reset
//                  key        in   128  cipher key, sampled with first byte
//                  in_data    in   8    ciphertext byte (first -> [127:120])
//                  in_valid   in   1    in_data valid
//                  in_ready   out  1    block accepts a byte this cycle
//                  out_data   out  8    plaintext byte (first = [127:120])
//                  out_valid  out  1    out_data valid
//                  out_ready  in   1    consumer accepts out_data
//                  busy       out  1    not idle in LOAD with empty buffer
//  Revision    : 1.0 - initial release
// ============================================================================
module block_decrypt_serial
    import crypt_pkg::*;
#(
    parameter int ROUNDS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] key,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    if (ROUNDS < 1 || ROUNDS > 255) begin : g_rounds_range_check
        $error("block_decrypt_serial: ROUNDS must be in 1..255");
    end

    localparam logic [7:0] c_last_rnd  = 8'(ROUNDS - 1);
    localparam logic [3:0] c_last_byte = 4'(BLOCK_BYTES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    fsm_state_e         fsm_q,      fsm_d;
    logic [3:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]         rnd_q,      rnd_d;
    logic [BLOCK_W-1:0] key_reg_q,  key_reg_d;
    logic [BLOCK_W-1:0] state_q,    state_d;

    // ------------------------------------------------------------------------
    // Round datapath: key XOR, rotate right one byte, inverse S-box per byte
    // ------------------------------------------------------------------------
    logic [BLOCK_W-1:0] w_round_key;
    logic [BLOCK_W-1:0] w_mixed;
    logic [BLOCK_W-1:0] w_rotated;
    logic [BLOCK_W-1:0] w_sbox_out;

    assign w_round_key = round_key(key_reg_q, rnd_q);
    assign w_mixed     = state_q ^ w_round_key;
    assign w_rotated   = {w_mixed[7:0], w_mixed[BLOCK_W-1:8]};

    for (genvar i = 0; i < BLOCK_BYTES; i++) begin : g_inv_sbox
        inv_s_box_gf u_inv_s_box (
            .sel  (w_rotated[i*8 +: 8]),
            .data (w_sbox_out[i*8 +: 8])
        );
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= LOAD;
            byte_cnt_q <= 4'd0;
            rnd_q      <= 8'd0;
            key_reg_q  <= '0;
            state_q    <= '0;
        end else begin
            fsm_q      <= fsm_d;
            byte_cnt_q <= byte_cnt_d;
            rnd_q      <= rnd_d;
            key_reg_q  <= key_reg_d;
            state_q    <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        fsm_d      = fsm_q;
        byte_cnt_d = byte_cnt_q;
        rnd_d      = rnd_q;
        key_reg_d  = key_reg_q;
        state_d    = state_q;

        case (fsm_q)
            LOAD: begin
                if (in_valid) begin
                    state_d    = {state_q[BLOCK_W-9:0], in_data};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    // Key is latched with the first byte so later key
                    // changes cannot corrupt a block already in flight.
                    if (byte_cnt_q == 4'd0) begin
                        key_reg_d = key;
                    end
                    if (byte_cnt_q == c_last_byte) begin
                        byte_cnt_d = 4'd0;
                        rnd_d      = c_last_rnd;
                        fsm_d      = ROUND;
                    end
                end
            end

            ROUND: begin
                state_d = w_sbox_out;
                if (rnd_q == 8'd0) begin
                    fsm_d = UNLOAD;
                end else begin
                    rnd_d = rnd_q - 8'd1;
                end
            end

            UNLOAD: begin
                if (out_ready) begin
                    state_d    = {state_q[BLOCK_W-9:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == c_last_byte) begin
                        byte_cnt_d = 4'd0;
                        fsm_d      = LOAD;
                    end
                end
            end

            default: begin
                fsm_d = LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // ------------------------------------------------------------------------
    assign in_ready  = (fsm_q == LOAD);
    assign out_valid = (fsm_q == UNLOAD);
    // Output byte is forced to zero outside UNLOAD so partial load data
    // never appears on the consumer bus.
    assign out_data  = out_valid ? state_q[BLOCK_W-1 -: 8] : 8'h00;
    assign busy      = (fsm_q != LOAD) || (byte_cnt_q != 4'd0);

endmodule : block_decrypt_serial
`default_nettype wire

// File: tb/tb_block_decrypt_serial.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_block_decrypt_serial
//  Description : Self-checking bench for block_decrypt_serial. Three
//                instances (ROUNDS = 1, 2, 10) share clock, reset and input
//                buses; sel steers handshakes to one instance at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_block_decrypt_serial;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         out_ready;
    logic [1:0]   sel;

    logic [2:0]       in_ready_w;
    logic [2:0]       out_valid_w;
    logic [2:0]       busy_w;
    logic [2:0][7:0]  out_data_w;

    logic       in_ready;
    logic       out_valid;
    logic       busy;
    logic [7:0] out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    block_decrypt_serial #(.ROUNDS(1)) u_dut_r1 (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .in_data   (in_data),
        .in_valid  (in_valid && (sel == 2'd0)),
        .in_ready  (in_ready_w[0]),
        .out_data  (out_data_w[0]),
        .out_valid (out_valid_w[0]),
        .out_ready (out_ready && (sel == 2'd0)),
        .busy      (busy_w[0])
    );

    block_decrypt_serial #(.ROUNDS(2)) u_dut_r2 (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .in_data   (in_data),
        .in_valid  (in_valid && (sel == 2'd1)),
        .in_ready  (in_ready_w[1]),
        .out_data  (out_data_w[1]),
        .out_valid (out_valid_w[1]),
        .out_ready (out_ready && (sel == 2'd1)),
        .busy      (busy_w[1])
    );

    block_decrypt_serial #(.ROUNDS(10)) u_dut_r10 (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .in_data   (in_data),
        .in_valid  (in_valid && (sel == 2'd2)),
        .in_ready  (in_ready_w[2]),
        .out_data  (out_data_w[2]),
        .out_valid (out_valid_w[2]),
        .out_ready (out_ready && (sel == 2'd2)),
        .busy      (busy_w[2])
    );

    assign in_ready  = in_ready_w[sel];
    assign out_valid = out_valid_w[sel];
    assign busy      = busy_w[sel];
    assign out_data  = out_data_w[sel];

    // ------------------------------------------------------------------------
    task automatic check_value(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Forward cipher: S-box (x^FF), rotate left one byte, XOR round key,
    // rounds applied 0 .. rounds-1.
    function automatic logic [127:0] encrypt(input logic [127:0] pt,
                                             input logic [127:0] k,
                                             input int rounds);
        logic [127:0] s;
        logic [7:0]   rb;
        s = pt;
        for (int r = 0; r < rounds; r++) begin
            rb = 8'(r);
            s  = s ^ {16{8'hFF}};
            s  = {s[119:0], s[127:120]};
            s  = s ^ k ^ {16{rb}};
        end
        return s;
    endfunction

    // Called and returns at a negedge.
    task automatic send_block(input logic [127:0] blk, input logic [127:0] k,
                              input bit gaps, input bit scramble_key);
        int w;
        for (int i = 0; i < 16; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_data  = blk[127-8*i -: 8];
            in_valid = 1'b1;
            key      = (scramble_key && i > 0) ?
                       {$urandom(), $urandom(), $urandom(), $urandom()} : k;
            w = 0;
            while (!in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                check_value("in_ready_timeout", 128'(in_ready), 128'(1));
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Collects bytes until abort_at (exclusive); optionally stalls 5 cycles
    // at byte stall_at and checks the held byte each stalled cycle.
    task automatic recv_block(input logic [127:0] exp, input int stall_at,
                              input int abort_at, output logic [127:0] blk);
        int w;
        blk = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) return;
            w = 0;
            while (!out_valid && w < 64) begin
                @(negedge clk);
                w++;
            end
            if (!out_valid) begin
                check_value("out_valid_timeout", 128'(out_valid), 128'(1));
                out_ready = 1'b0;
                return;
            end
            if (i == stall_at) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_value("stall_hold", 128'({out_valid, out_data}),
                                128'({1'b1, exp[127-8*i -: 8]}));
                end
            end
            out_ready = 1'b1;
            blk[127-8*i -: 8] = out_data;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    // Negedges from the one after the last input accept until out_valid.
    task automatic measure_latency(input int exp_cycles);
        int n;
        n = 0;
        check_value("busy_in_round", 128'(busy), 128'(1));
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_value("latency", 128'(n), 128'(exp_cycles));
    endtask

    task automatic check_idle(input string tag);
        check_value({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check_value({tag, "_in_ready"},  128'(in_ready),  128'(1));
        check_value({tag, "_busy"},      128'(busy),      128'(0));
        check_value({tag, "_out_data"},  128'(out_data),  128'(0));
    endtask

    // ------------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] got;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] k;

        rst = 1'b1; key = '0; in_data = '0; in_valid = 1'b0;
        out_ready = 1'b0; sel = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state on every instance
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check_idle("reset");
        end
        @(negedge clk);

        // ROUNDS=1, key 0, all-zero block -> all 0xFF
        sel = 2'd0;
        send_block('0, '0, 1'b0, 1'b0);
        measure_latency(1);
        recv_block('0, -1, -1, got);
        check_value("r1_zero", got, {16{8'hFF}});

        // ROUNDS=1, key 0, ascending bytes
        send_block(128'h00010203_04050607_08090A0B_0C0D0E0F, '0, 1'b0, 1'b0);
        measure_latency(1);
        recv_block('0, -1, -1, got);
        check_value("r1_ramp", got, 128'hF0FFFEFD_FCFBFAF9_F8F7F6F5_F4F3F2F1);

        // ROUNDS=2, key 0, zeros -> all 0x01
        sel = 2'd1;
        send_block('0, '0, 1'b0, 1'b0);
        measure_latency(2);
        recv_block('0, -1, -1, got);
        check_value("r2_zero", got, {16{8'h01}});

        // Stalls on both sides: same bytes as the unstalled ramp run
        sel = 2'd0;
        send_block(128'h00010203_04050607_08090A0B_0C0D0E0F, '0, 1'b1, 1'b0);
        recv_block(128'hF0FFFEFD_FCFBFAF9_F8F7F6F5_F4F3F2F1, 7, -1, got);
        check_value("stall_ramp", got, 128'hF0FFFEFD_FCFBFAF9_F8F7F6F5_F4F3F2F1);

        // Reset during ROUND
        sel = 2'd2;
        k  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        pt = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
        send_block(encrypt(pt, k, 10), k, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_value("in_round_before_rst", 128'(busy), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_round");

        // Reset at UNLOAD byte 7 while the consumer is accepting
        send_block(encrypt(pt, k, 10), k, 1'b0, 1'b0);
        recv_block('0, -1, 7, got);
        check_value("partial_bytes", got[127:72], pt[127:72]);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        check_idle("rst_unload");

        // Reset together with a valid input byte: byte must be dropped
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check_value("rst_drops_byte", 128'(busy), 128'(0));

        // Full block after the aborts
        send_block(encrypt(pt, k, 10), k, 1'b0, 1'b0);
        recv_block('0, -1, -1, got);
        check_value("after_reset", got, pt);

        // Round trip with key scrambled after byte 0
        for (int n = 0; n < 100; n++) begin
            k  = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct = encrypt(pt, k, 10);
            send_block(ct, k, n[0], 1'b1);
            recv_block('0, -1, -1, got);
            check_value("round_trip", got, pt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_block_decrypt_serial
`default_nettype wire
